semaphore_bank: RTL and testbench

- Receiving end of the per-core semaphore write-enable lines.
- Holds NumberOfSemaphores hardware lock registers shared by NumberOfCores PLC cores.
- Each cycle it samples every core's WE strobe per semaphore together with that core's acquire/release data bit.
- It arbitrates contention round-robin, updates ownership and returns a one-cycle acknowledge with pass/fail per strobe.

---
 rtl/semaphore_pkg.sv | 22 ++
 rtl/semaphore_rr_arbiter.sv | 33 +++
 rtl/semaphore_bank.sv | 164 ++++++++++++++++
 tb/tb_semaphore_bank.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/semaphore_pkg.sv
// rtl/semaphore_pkg.sv - shared op encodings and index helpers for the semaphore bank
package semaphore_pkg;

    localparam logic SEM_OP_ACQUIRE = 1'b1;
    localparam logic SEM_OP_RELEASE = 1'b0;

    // Flat strobe/ack bit position for a (core, semaphore) pair.
    function automatic int sem_bit_idx(input int core, input int sem, input int num_sems);
        return core * num_sems + sem;
    endfunction

    // Ceiling log2, never less than 1 so a single-core index still has a bit.
    function automatic int sem_clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/semaphore_rr_arbiter.sv
// rtl/semaphore_rr_arbiter.sv - round-robin pick of one acquiring core for a single semaphore
module semaphore_rr_arbiter #(
    parameter int NumCores = 2,
    parameter int IdxWidth = 1
) (
    input  logic [NumCores-1:0] req_i,
    input  logic [IdxWidth-1:0] ptr_i,
    output logic [NumCores-1:0] grant_o,
    output logic [IdxWidth-1:0] winner_o,
    output logic                valid_o
);

    int   idx;
    logic found;

    // Scan starting at the pointer and wrapping; the first requester seen wins.
    always_comb begin
        grant_o  = '0;
        winner_o = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < NumCores; k++) begin
            idx = (int'(ptr_i) + k) % NumCores;
            if (!found && req_i[idx]) begin
                found         = 1'b1;
                grant_o[idx]  = 1'b1;
                winner_o      = IdxWidth'(idx);
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/semaphore_bank.sv
// rtl/semaphore_bank.sv - shared hardware lock bank with round-robin grant; SEMAPHOREBANK_TIMEOUT_EN adds lease expiry
module semaphore_bank
    import semaphore_pkg::*;
#(
    parameter int NumberOfSemaphores = 4,
    parameter int NumberOfCores      = 2,
    parameter int OwnerWidth         = 1,
    parameter int TimeoutCycles      = 1024
) (
    input  logic                                       SEMAPHOREBANK_clk,
    input  logic                                       SEMAPHOREBANK_rst,
    input  logic [NumberOfSemaphores*NumberOfCores-1:0] SEMAPHOREBANK_WE,
    input  logic [NumberOfCores-1:0]                   SEMAPHOREBANK_DATA,
    output logic [NumberOfSemaphores*NumberOfCores-1:0] SEMAPHOREBANK_ACK,
    output logic [NumberOfSemaphores*NumberOfCores-1:0] SEMAPHOREBANK_RESULT,
    output logic [NumberOfSemaphores-1:0]              SEMAPHOREBANK_LOCKED,
    output logic [NumberOfSemaphores*OwnerWidth-1:0]   SEMAPHOREBANK_OWNER,
    output logic [NumberOfSemaphores-1:0]              SEMAPHOREBANK_TIMEOUT
);

    localparam int NumBits = NumberOfSemaphores * NumberOfCores;

    logic [NumberOfSemaphores-1:0] locked_q, locked_d;
    logic [OwnerWidth-1:0]         owner_q [NumberOfSemaphores];
    logic [OwnerWidth-1:0]         owner_d [NumberOfSemaphores];
    logic [OwnerWidth-1:0]         ptr_q   [NumberOfSemaphores];
    logic [OwnerWidth-1:0]         ptr_d   [NumberOfSemaphores];
    logic [NumBits-1:0]            ack_q, ack_d;
    logic [NumBits-1:0]            result_q, result_d;

    logic [NumberOfCores-1:0]      free_acq_req [NumberOfSemaphores];
    logic [NumberOfCores-1:0]      grant        [NumberOfSemaphores];
    logic [OwnerWidth-1:0]         winner       [NumberOfSemaphores];
    logic [NumberOfSemaphores-1:0] grant_valid;
    logic [NumberOfSemaphores-1:0] owner_rel;

`ifdef SEMAPHOREBANK_TIMEOUT_EN
    localparam int CntWidth = sem_clog2(TimeoutCycles);

    logic [CntWidth-1:0]           cnt_q [NumberOfSemaphores];
    logic [CntWidth-1:0]           cnt_d [NumberOfSemaphores];
    logic [NumberOfSemaphores-1:0] timeout_q, timeout_d;
`endif

    // Only a semaphore that is free at the start of the cycle can be granted.
    always_comb begin
        free_acq_req = '{default: '0};
        for (int s = 0; s < NumberOfSemaphores; s++) begin
            for (int c = 0; c < NumberOfCores; c++) begin
                free_acq_req[s][c] = SEMAPHOREBANK_WE[sem_bit_idx(c, s, NumberOfSemaphores)]
                                     && (SEMAPHOREBANK_DATA[c] == SEM_OP_ACQUIRE)
                                     && !locked_q[s];
            end
        end
    end

    for (genvar gs = 0; gs < NumberOfSemaphores; gs++) begin : g_arb
        semaphore_rr_arbiter #(
            .NumCores (NumberOfCores),
            .IdxWidth (OwnerWidth)
        ) u_arb (
            .req_i    (free_acq_req[gs]),
            .ptr_i    (ptr_q[gs]),
            .grant_o  (grant[gs]),
            .winner_o (winner[gs]),
            .valid_o  (grant_valid[gs])
        );
    end

    always_comb begin
        locked_d  = locked_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        ack_d     = SEMAPHOREBANK_WE;
        result_d  = '0;
        owner_rel = '0;
`ifdef SEMAPHOREBANK_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
`endif
        for (int s = 0; s < NumberOfSemaphores; s++) begin
            for (int c = 0; c < NumberOfCores; c++) begin
                if (SEMAPHOREBANK_WE[sem_bit_idx(c, s, NumberOfSemaphores)]) begin
                    if (SEMAPHOREBANK_DATA[c] == SEM_OP_RELEASE) begin
                        if (locked_q[s] && (owner_q[s] == OwnerWidth'(c))) begin
                            result_d[sem_bit_idx(c, s, NumberOfSemaphores)] = 1'b1;
                            owner_rel[s] = 1'b1;
                        end
                    end else begin
                        result_d[sem_bit_idx(c, s, NumberOfSemaphores)] = grant[s][c];
                    end
                end
            end

            if (owner_rel[s]) begin
                locked_d[s] = 1'b0;
                owner_d[s]  = '0;
`ifdef SEMAPHOREBANK_TIMEOUT_EN
                cnt_d[s]     = '0;
                timeout_d[s] = 1'b0;
`endif
            end else if (grant_valid[s]) begin
                locked_d[s] = 1'b1;
                owner_d[s]  = winner[s];
                ptr_d[s]    = (winner[s] == OwnerWidth'(NumberOfCores - 1))
                              ? '0 : winner[s] + OwnerWidth'(1);
`ifdef SEMAPHOREBANK_TIMEOUT_EN
                cnt_d[s]    = '0;
            end else if (locked_q[s]) begin
                // Lease expiry takes the lock back from a core that never released it.
                if (cnt_q[s] == CntWidth'(TimeoutCycles - 1)) begin
                    locked_d[s]  = 1'b0;
                    owner_d[s]   = '0;
                    cnt_d[s]     = '0;
                    timeout_d[s] = 1'b1;
                end else begin
                    cnt_d[s] = cnt_q[s] + CntWidth'(1);
                end
`endif
            end
        end
    end

    always_ff @(posedge SEMAPHOREBANK_clk) begin
        if (SEMAPHOREBANK_rst) begin
            locked_q  <= '0;
            owner_q   <= '{default: '0};
            ptr_q     <= '{default: '0};
            ack_q     <= '0;
            result_q  <= '0;
`ifdef SEMAPHOREBANK_TIMEOUT_EN
            cnt_q     <= '{default: '0};
            timeout_q <= '0;
`endif
        end else begin
            locked_q  <= locked_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            ack_q     <= ack_d;
            result_q  <= result_d;
`ifdef SEMAPHOREBANK_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    always_comb begin
        SEMAPHOREBANK_OWNER = '0;
        for (int s = 0; s < NumberOfSemaphores; s++) begin
            SEMAPHOREBANK_OWNER[s*OwnerWidth +: OwnerWidth] = owner_q[s];
        end
    end

    assign SEMAPHOREBANK_ACK    = ack_q;
    assign SEMAPHOREBANK_RESULT = result_q;
    assign SEMAPHOREBANK_LOCKED = locked_q;
`ifdef SEMAPHOREBANK_TIMEOUT_EN
    assign SEMAPHOREBANK_TIMEOUT = timeout_q;
`else
    assign SEMAPHOREBANK_TIMEOUT = '0;
`endif

endmodule

// File: tb/tb_semaphore_bank.sv
// tb/tb_semaphore_bank.sv - self-checking bench for semaphore_bank; timeout scenario built with SEMAPHOREBANK_TIMEOUT_EN
module tb_semaphore_bank;

    localparam int S  = 4;
    localparam int C  = 2;
    localparam int NB = S * C;
`ifdef SEMAPHOREBANK_TIMEOUT_EN
    localparam int T  = 8;
`else
    localparam int T  = 1024;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] we = '0;
    logic [C-1:0]  data = '0;
    logic [NB-1:0] ack, result;
    logic [S-1:0]  locked, timeout;
    logic [S-1:0]  owner;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: who holds what, and how long it has been held.
    bit            m_locked [S];
    int            m_owner  [S];
    int            m_ptr    [S];
    int            m_age    [S];
    bit            m_to     [S];
    logic [NB-1:0] exp_ack, exp_res;

    semaphore_bank #(
        .NumberOfSemaphores (S),
        .NumberOfCores      (C),
        .OwnerWidth         (1),
        .TimeoutCycles      (T)
    ) dut (
        .SEMAPHOREBANK_clk     (clk),
        .SEMAPHOREBANK_rst     (rst),
        .SEMAPHOREBANK_WE      (we),
        .SEMAPHOREBANK_DATA    (data),
        .SEMAPHOREBANK_ACK     (ack),
        .SEMAPHOREBANK_RESULT  (result),
        .SEMAPHOREBANK_LOCKED  (locked),
        .SEMAPHOREBANK_OWNER   (owner),
        .SEMAPHOREBANK_TIMEOUT (timeout)
    );

    always #5 clk = ~clk;

    task automatic model_step(input logic [NB-1:0] w, input logic [C-1:0] d, input logic r);
        bit rel_ok;
        int win;
        int c;
        exp_ack = '0;
        exp_res = '0;
        if (r) begin
            for (int s = 0; s < S; s++) begin
                m_locked[s] = 0; m_owner[s] = 0; m_ptr[s] = 0; m_age[s] = 0; m_to[s] = 0;
            end
            return;
        end
        exp_ack = w;
        for (int s = 0; s < S; s++) begin
            rel_ok = 0;
            win    = -1;
            for (int k = 0; k < C; k++) begin
                if (w[k*S+s] && d[k] == 1'b0 && m_locked[s] && m_owner[s] == k) begin
                    exp_res[k*S+s] = 1'b1;
                    rel_ok = 1;
                end
            end
            if (!m_locked[s]) begin
                for (int k = 0; k < C; k++) begin
                    c = (m_ptr[s] + k) % C;
                    if (win < 0 && w[c*S+s] && d[c]) win = c;
                end
            end
            if (win >= 0) exp_res[win*S+s] = 1'b1;
            if (rel_ok) begin
                m_locked[s] = 0; m_owner[s] = 0; m_age[s] = 0; m_to[s] = 0;
            end else if (win >= 0) begin
                m_locked[s] = 1; m_owner[s] = win; m_ptr[s] = (win + 1) % C; m_age[s] = 0;
            end else if (m_locked[s]) begin
`ifdef SEMAPHOREBANK_TIMEOUT_EN
                if (m_age[s] == T - 1) begin
                    m_locked[s] = 0; m_owner[s] = 0; m_age[s] = 0; m_to[s] = 1;
                end else begin
                    m_age[s]++;
                end
`endif
            end
        end
    endtask

    task automatic step(input logic [NB-1:0] w, input logic [C-1:0] d, input logic r);
        we = w; data = d; rst = r;
        model_step(w, d, r);
        @(posedge clk);
        #1;
        we = '0; data = '0; rst = 1'b0;
    endtask

    task automatic test_reset();
        step('0, '0, 1'b1);
        n_tests++; if (ack !== '0)     begin n_fail++; $display("FAIL reset_ack: got %h want 00", ack); end
        n_tests++; if (result !== '0)  begin n_fail++; $display("FAIL reset_result: got %h want 00", result); end
        n_tests++; if (locked !== '0)  begin n_fail++; $display("FAIL reset_locked: got %h want 0", locked); end
        n_tests++; if (owner !== '0)   begin n_fail++; $display("FAIL reset_owner: got %h want 0", owner); end
        n_tests++; if (timeout !== '0) begin n_fail++; $display("FAIL reset_timeout: got %h want 0", timeout); end
    endtask

    task automatic test_single();
        step(8'h04, 2'b01, 1'b0);
        n_tests++; if (ack !== 8'h04)    begin n_fail++; $display("FAIL single_acq_ack: got %h want 04", ack); end
        n_tests++; if (result !== 8'h04) begin n_fail++; $display("FAIL single_acq_result: got %h want 04", result); end
        n_tests++; if (locked !== 4'b0100) begin n_fail++; $display("FAIL single_acq_locked: got %b want 0100", locked); end
        n_tests++; if (owner !== 4'b0000)  begin n_fail++; $display("FAIL single_acq_owner: got %b want 0000", owner); end
        step(8'h04, 2'b00, 1'b0);
        n_tests++; if (result !== 8'h04) begin n_fail++; $display("FAIL single_rel_result: got %h want 04", result); end
        n_tests++; if (locked !== 4'b0000) begin n_fail++; $display("FAIL single_rel_locked: got %b want 0000", locked); end
        step('0, '0, 1'b0);
        n_tests++; if (ack !== '0) begin n_fail++; $display("FAIL single_ack_pulse: got %h want 00", ack); end
    endtask

    task automatic test_contention();
        step(8'h11, 2'b11, 1'b0);
        n_tests++; if (result !== 8'h01) begin n_fail++; $display("FAIL contend1_result: got %h want 01", result); end
        n_tests++; if (ack !== 8'h11)    begin n_fail++; $display("FAIL contend1_ack: got %h want 11", ack); end
        step(8'h01, 2'b00, 1'b0);
        step(8'h11, 2'b11, 1'b0);
        n_tests++; if (result !== 8'h10) begin n_fail++; $display("FAIL contend2_result: got %h want 10", result); end
        n_tests++; if (owner !== 4'b0001) begin n_fail++; $display("FAIL contend2_owner: got %b want 0001", owner); end
        step(8'h10, 2'b00, 1'b0);
        n_tests++; if (result !== 8'h10 || locked[0] !== 1'b0) begin
            n_fail++; $display("FAIL contend2_release: result %h locked %b want 10 / 0", result, locked);
        end
    endtask

    task automatic test_illegal();
        step(8'h02, 2'b01, 1'b0);
        step(8'h20, 2'b00, 1'b0);
        n_tests++; if (result !== 8'h00 || ack !== 8'h20) begin
            n_fail++; $display("FAIL foreign_release: result %h ack %h want 00 / 20", result, ack);
        end
        n_tests++; if (locked !== 4'b0010 || owner !== 4'b0000) begin
            n_fail++; $display("FAIL foreign_release_state: locked %b owner %b want 0010 / 0000", locked, owner);
        end
        step(8'h02, 2'b01, 1'b0);
        n_tests++; if (result !== 8'h00) begin n_fail++; $display("FAIL recursive_acquire: got %h want 00", result); end
        step(8'h80, 2'b00, 1'b0);
        n_tests++; if (result !== 8'h00) begin n_fail++; $display("FAIL free_release: got %h want 00", result); end
        step(8'h02, 2'b00, 1'b0);
        n_tests++; if (result !== 8'h02 || locked !== '0) begin
            n_fail++; $display("FAIL illegal_cleanup: result %h locked %b want 02 / 0000", result, locked);
        end
    endtask

    task automatic test_back_to_back();
        step(8'h01, 2'b01, 1'b0);
        step(8'h11, 2'b10, 1'b0);
        n_tests++; if (result !== 8'h01) begin n_fail++; $display("FAIL relacq_result: got %h want 01", result); end
        n_tests++; if (locked[0] !== 1'b0) begin n_fail++; $display("FAIL relacq_locked: got %b want 0", locked[0]); end
        step(8'h10, 2'b10, 1'b0);
        n_tests++; if (result !== 8'h10 || owner !== 4'b0001) begin
            n_fail++; $display("FAIL relacq_retry: result %h owner %b want 10 / 0001", result, owner);
        end
        step(8'h10, 2'b00, 1'b0);
    endtask

    task automatic test_reset_mid();
        step(8'h84, 2'b11, 1'b0);
        n_tests++; if (locked !== 4'b1100 || owner !== 4'b1000) begin
            n_fail++; $display("FAIL mid_hold: locked %b owner %b want 1100 / 1000", locked, owner);
        end
        step(8'h01, 2'b01, 1'b1);
        n_tests++; if (ack !== '0 || locked !== '0 || owner !== '0) begin
            n_fail++; $display("FAIL mid_reset: ack %h locked %b owner %b want all zero", ack, locked, owner);
        end
        step(8'h44, 2'b11, 1'b0);
        n_tests++; if (ack !== 8'h44) begin n_fail++; $display("FAIL mid_dropped_strobe: ack %h want 44", ack); end
        n_tests++; if (result !== 8'h04) begin n_fail++; $display("FAIL mid_ptr_reset: result %h want 04", result); end
        step(8'h04, 2'b00, 1'b0);
    endtask

`ifdef SEMAPHOREBANK_TIMEOUT_EN
    task automatic test_timeout();
        step('0, '0, 1'b1);
        step(8'h02, 2'b01, 1'b0);
        for (int k = 1; k < T; k++) begin
            step('0, '0, 1'b0);
            n_tests++; if (locked[1] !== 1'b1 || timeout[1] !== 1'b0) begin
                n_fail++; $display("FAIL lease_hold_%0d: locked %b timeout %b want 1 / 0", k, locked[1], timeout[1]);
            end
        end
        step('0, '0, 1'b0);
        n_tests++; if (locked[1] !== 1'b0 || timeout[1] !== 1'b1) begin
            n_fail++; $display("FAIL lease_expire: locked %b timeout %b want 0 / 1", locked[1], timeout[1]);
        end
        step(8'h02, 2'b01, 1'b0);
        n_tests++; if (result !== 8'h02 || timeout[1] !== 1'b1) begin
            n_fail++; $display("FAIL lease_reacquire: result %h timeout %b want 02 / 1", result, timeout[1]);
        end
        step(8'h02, 2'b00, 1'b0);
        n_tests++; if (result !== 8'h02 || timeout[1] !== 1'b0) begin
            n_fail++; $display("FAIL lease_clear: result %h timeout %b want 02 / 0", result, timeout[1]);
        end
    endtask
`endif

    task automatic test_random();
        logic [S-1:0]  e_locked, e_owner, e_to;
        logic [NB-1:0] w;
        logic [C-1:0]  d;
        logic          r;
        step('0, '0, 1'b1);
        for (int n = 0; n < 400; n++) begin
            w = NB'($urandom & $urandom);
            d = C'($urandom);
            r = ($urandom_range(0, 63) == 0);
            step(w, d, r);
            for (int s = 0; s < S; s++) begin
                e_locked[s] = m_locked[s];
                e_owner[s]  = (m_owner[s] != 0);
`ifdef SEMAPHOREBANK_TIMEOUT_EN
                e_to[s]     = m_to[s];
`else
                e_to[s]     = 1'b0;
`endif
            end
            n_tests++; if (ack !== exp_ack)     begin n_fail++; $display("FAIL rnd_ack[%0d]: got %h want %h", n, ack, exp_ack); end
            n_tests++; if (result !== exp_res)  begin n_fail++; $display("FAIL rnd_result[%0d]: got %h want %h", n, result, exp_res); end
            n_tests++; if (locked !== e_locked) begin n_fail++; $display("FAIL rnd_locked[%0d]: got %b want %b", n, locked, e_locked); end
            n_tests++; if (owner !== e_owner)   begin n_fail++; $display("FAIL rnd_owner[%0d]: got %b want %b", n, owner, e_owner); end
            n_tests++; if (timeout !== e_to)    begin n_fail++; $display("FAIL rnd_timeout[%0d]: got %b want %b", n, timeout, e_to); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
`ifdef SEMAPHOREBANK_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
